// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA FSM states and fixed bus addresses.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG      = 16'h4014;
  localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;
  localparam int unsigned OAM_DMA_LEN      = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA controller and CPU/DMA memory-bus arbiter.
// Build option OAM_DMA_PARITY_EN: track bus parity and insert ALIGN so reads land on even cycles.
module oam_dma_ctrl
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  output logic [7:0]  cpu_din,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_r_nw,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_DMA_LEN - 1);

  dma_state_t state, state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic       trigger;

  assign trigger = (state == IDLE) && !cpu_r_nw && (cpu_addr == OAM_DMA_REG);
  assign cpu_din = mem_rdata;

`ifdef OAM_DMA_PARITY_EN
  logic parity;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) parity <= 1'b0;
    else         parity <= ~parity;
  end
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      page  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (trigger) begin
        page <= cpu_dout;
        idx  <= '0;
      end else if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_dout;
    mem_r_nw   = 1'b1;
    cpu_ready  = 1'b0;
    dma_active = 1'b1;
    unique case (state)
      IDLE: begin
        cpu_ready  = 1'b1;
        dma_active = 1'b0;
        mem_r_nw   = cpu_r_nw;
        if (trigger) state_nxt = HALT;
      end
      HALT: begin
`ifdef OAM_DMA_PARITY_EN
        // parity now is the opposite of the next cycle's; READ needs the next one even
        state_nxt = parity ? READ : ALIGN;
`else
        state_nxt = READ;
`endif
      end
      ALIGN: state_nxt = READ;
      READ: begin
        mem_addr  = {page, idx};
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr  = PPU_OAMDATA_ADDR;
        mem_wdata = mem_rdata;
        mem_r_nw  = 1'b0;
        state_nxt = (idx == LAST_IDX) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: passthrough vectors plus DMA, reset and back-to-back sequences.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk;
  logic        nreset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  cpu_din;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_r_nw;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  oam_dma_ctrl dut (
    .clk        (clk),
    .nreset     (nreset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_r_nw   (cpu_r_nw),
    .cpu_din    (cpu_din),
    .cpu_ready  (cpu_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_r_nw   (mem_r_nw),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  wram [0:65535];
  logic [7:0]  wlog [$];
  logic [31:0] cyc;
  int n_chk  = 0;
  int n_fail = 0;

  // Synchronous-read memory; every write to OAMDATA is logged in order.
  always @(posedge clk) begin
    mem_rdata <= wram[mem_addr];
    if (nreset && !mem_r_nw && mem_addr == 16'h2004) wlog.push_back(mem_wdata);
  end

  // Posedges since reset release; bit 0 is the bus parity of the current cycle.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) cyc <= '0;
    else         cyc <= cyc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input logic [7:0] pg, input int i);
    logic [7:0] b;
    b = 8'(i);
    return (pg == 8'h03) ? (b ^ 8'h5A) : ~b;
  endfunction

  task automatic wait_parity(input bit want);
    for (int i = 0; i < 3 && cyc[0] != want; i++) tick();
  endtask

  task automatic trigger(input logic [7:0] pg, output bit q, output int base);
    cpu_addr = 16'h4014;
    cpu_dout = pg;
    cpu_r_nw = 1'b0;
    q        = cyc[0];
    base     = wlog.size();
    #1;
    check("trig_mem_addr", 32'(mem_addr), 32'h4014);
    check("trig_mem_r_nw", 32'(mem_r_nw), 32'h0);
    tick();
    cpu_addr = 16'h8000;
    cpu_dout = 8'h00;
    cpu_r_nw = 1'b1;
    #1;
    check("halt_cpu_ready", 32'(cpu_ready), 32'h0);
    check("halt_dma_active", 32'(dma_active), 32'h1);
    check("halt_mem_r_nw", 32'(mem_r_nw), 32'h1);
    check("halt_mem_addr", 32'(mem_addr), 32'h8000);
  endtask

  task automatic wait_done(input int exp_susp, input logic [7:0] pg, input int base);
    int susp = 1;
    bit done = 1'b0;
    for (int i = 0; i < 700 && !done; i++) begin
      tick();
      if (cpu_ready) done = 1'b1;
      else           susp++;
    end
    check("susp_cycles", 32'(susp), 32'(exp_susp));
    check("dma_active_end", 32'(dma_active), 32'h0);
    check("dma_write_count", 32'(wlog.size() - base), 32'd256);
    for (int i = 0; i < 256; i++)
      if (base + i < wlog.size()) check($sformatf("dma_data[%0d]", i), 32'(wlog[base + i]), 32'(pat(pg, i)));
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        r_nw;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_r_nw;
    bit          din_chk;
    logic [7:0]  exp_din;
  } vec_t;

  initial begin
    vec_t vecs[9];
    bit   q;
    int   base;

    for (int i = 0; i < 65536; i++) wram[i] = 8'h00;
    wram[16'h0123] = 8'hA7;
    wram[16'h0124] = 8'h3C;
    for (int i = 0; i < 256; i++) begin
      wram[16'h0200 + i] = ~8'(i);
      wram[16'h0300 + i] = 8'(i) ^ 8'h5A;
    end

    vecs[0] = '{16'h0123, 8'h00, 1'b1, 16'h0123, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{16'h0124, 8'h00, 1'b1, 16'h0124, 8'h00, 1'b1, 1'b1, 8'hA7};
    vecs[2] = '{16'h0200, 8'h55, 1'b0, 16'h0200, 8'h55, 1'b0, 1'b1, 8'h3C};
    vecs[3] = '{16'h4015, 8'h80, 1'b0, 16'h4015, 8'h80, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{16'h4013, 8'h02, 1'b0, 16'h4013, 8'h02, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{16'h4014, 8'h07, 1'b1, 16'h4014, 8'h07, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{16'h0123, 8'h00, 1'b1, 16'h0123, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{16'h0124, 8'h9E, 1'b1, 16'h0124, 8'h9E, 1'b1, 1'b1, 8'hA7};
    vecs[8] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 8'h00, 1'b1, 1'b1, 8'h3C};

    // Reset with random CPU activity.
    nreset   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_r_nw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 16'($urandom);
      cpu_dout = 8'($urandom);
      cpu_r_nw = 1'($urandom);
      #7;
      check("rst_cpu_ready", 32'(cpu_ready), 32'h1);
      check("rst_dma_active", 32'(dma_active), 32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'(cpu_addr));
      if (cpu_r_nw) check("rst_mem_r_nw", 32'(mem_r_nw), 32'h1);
    end
    cpu_addr = 16'h8000;
    cpu_r_nw = 1'b1;
    tick();
    nreset = 1'b1;
    tick();

    // Idle passthrough vectors.
    foreach (vecs[i]) begin
      cpu_addr = vecs[i].addr;
      cpu_dout = vecs[i].dout;
      cpu_r_nw = vecs[i].r_nw;
      #1;
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].exp_wdata));
      check($sformatf("v%0d_mem_r_nw", i), 32'(mem_r_nw), 32'(vecs[i].exp_r_nw));
      check($sformatf("v%0d_cpu_ready", i), 32'(cpu_ready), 32'h1);
      check($sformatf("v%0d_dma_active", i), 32'(dma_active), 32'h0);
      if (vecs[i].din_chk) check($sformatf("v%0d_cpu_din", i), 32'(cpu_din), 32'(vecs[i].exp_din));
      tick();
    end
    check("idle_no_oam_writes", 32'(wlog.size()), 32'h0);

    // Even-aligned DMA: the cycle after HALT is even, never needs ALIGN.
    wait_parity(1'b0);
    trigger(8'h02, q, base);
    wait_done(513, 8'h02, base);

    // Odd-aligned DMA, then back-to-back restart on the first ready cycle.
    wait_parity(1'b1);
    trigger(8'h02, q, base);
    wait_done(PEN ? 514 : 513, 8'h02, base);
    trigger(8'h03, q, base);
    wait_done((PEN && q) ? 514 : 513, 8'h03, base);

    // Reset in the middle of a transfer.
    trigger(8'h02, q, base);
    for (int i = 0; i < 400 && wlog.size() < base + 100; i++) tick();
    check("mid_write_count", 32'(wlog.size() - base), 32'd100);
    nreset = 1'b0;
    #1;
    check("mid_rst_cpu_ready", 32'(cpu_ready), 32'h1);
    check("mid_rst_dma_active", 32'(dma_active), 32'h0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'h8000);
    check("mid_rst_mem_r_nw", 32'(mem_r_nw), 32'h1);
    tick();
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("post_rst_no_writes", 32'(wlog.size() - base), 32'd100);
    check("post_rst_cpu_ready", 32'(cpu_ready), 32'h1);
    check("post_rst_dma_active", 32'(dma_active), 32'h0);
    trigger(8'h02, q, base);
    wait_done((PEN && q) ? 514 : 513, 8'h02, base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite OAM DMA controller and memory-bus arbiter between the CPU core and the WRAM/PPU-register bus. A CPU write to $4014 with value P halts the CPU through its ready input. The block then copies the 256 bytes at $PP00-$PPFF over the shared memory bus into the PPU OAMDATA register ($2004) and releases the CPU. When idle, the CPU bus passes through unchanged.

## Interface
Parameters: none.
- clk  in  1  system clock; all state on rising edge
- nreset  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU address bus
- cpu_dout  in  8  CPU write data
- cpu_r_nw  in  1  CPU R/!W (1 = read)
- cpu_din  out  8  data to CPU; always equals mem_rdata
- cpu_ready  out  1  CPU ready; 0 = CPU suspended
- mem_addr  out  16  address to WRAM/register decoder
- mem_wdata  out  8  write data to decoder
- mem_r_nw  out  1  R/!W to decoder (1 = read)
- mem_rdata  in  8  read data; synchronous, valid the cycle after the address
- dma_active  out  1  1 while the DMA owns the bus

## Operation
- Trigger: cpu_ready=1, cpu_r_nw=0, cpu_addr=16'h4014. Latch page=cpu_dout and go to HALT next cycle. The triggering write itself passes through to memory.
- States:
  - IDLE: passthrough. mem_addr=cpu_addr, mem_wdata=cpu_dout, mem_r_nw=cpu_r_nw, cpu_ready=1, dma_active=0.
  - HALT: one dummy cycle. cpu_ready=0, dma_active=1, mem_r_nw=1, mem_addr=cpu_addr. Go to ALIGN if required (see Timing), else READ.
  - ALIGN: one dummy cycle, same outputs as HALT. Go to READ.
  - READ: mem_addr={page,idx}, mem_r_nw=1. Go to WRITE.
  - WRITE: latch mem_rdata in the WRITE cycle and drive it the same cycle. mem_addr=16'h2004, mem_wdata=mem_rdata, mem_r_nw=0. Then idx+=1. If idx was 8'hFF, go to IDLE; else go to READ.
- idx is 8 bits, cleared on trigger. No wrap past $PPFF.
- All DMA-state outputs are registered-decoded from state. cpu_ready and dma_active are pure functions of state (IDLE ↔ ready).
- A trigger cannot occur while cpu_ready=0. Writes to $4014 during DMA are impossible by construction and are ignored.
- Page values $20-$3F are not special-cased: reads go to the decoder as-is.

## Timing
- Reset values: state=IDLE, page=0, idx=0, parity=0, cpu_ready=1, dma_active=0, mem_r_nw=1, mem_addr=cpu_addr (passthrough), mem_wdata=cpu_dout.
- parity toggles every clk out of reset. READ cycles occur only with parity=0.
- If the cycle after HALT has parity=1, insert ALIGN.
- Suspension length: cycles with cpu_ready=0 = 1 + align + 512, i.e. 513 or 514.
- cpu_ready returns to 1 in the cycle after the last WRITE.
- Reset mid-transfer: immediate return to reset values. No further $2004 writes. The partial copy is not resumed.

## Configuration
- OAM_DMA_PARITY_EN
  - Defined: parity tracking and ALIGN state as above (513/514 cycles).
  - Undefined: no parity register and no ALIGN. HALT always goes to READ, giving exactly 513 suspended cycles.

## Structure
- Shared package nes_pkg holds:
  - the dma_state_t enum (IDLE, HALT, ALIGN, READ, WRITE)
  - OAM_DMA_REG = 16'h4014
  - PPU_OAMDATA_ADDR = 16'h2004
  - OAM_DMA_LEN = 256
- Single module; no sub-module. The arbiter mux and FSM are small enough to stay flat.
- Instantiated between cpu and WRAM in cpu_toplevel. The cpu ready_in input is driven by cpu_ready ANDed with the system rdy.

## Test plan
- Reset: hold nreset=0 with random cpu inputs -> cpu_ready=1, dma_active=0, mem_addr follows cpu_addr, mem_r_nw=1 if cpu_r_nw=1.
- Idle passthrough: CPU read $0123, then write $55 to $0200 -> mem bus mirrors both. Writes to $4015 and $4013 never raise dma_active.
- Even-aligned DMA:
  - Preload WRAM $0200-$02FF with value = ~addr[7:0]. Write $02 to $4014 so that HALT+1 has parity=0.
  - Expect exactly 513 cycles with cpu_ready=0 and 256 writes to $2004 with data $FF,$FE,…,$00 in order.
- Odd-aligned DMA (OAM_DMA_PARITY_EN defined): same trigger shifted one cycle -> 514 suspended cycles, identical data. With the macro undefined -> 513.
- Reset mid-DMA: assert nreset after the 100th $2004 write -> outputs reset the same cycle. After release: no $2004 writes, cpu_ready=1. A new $4014 write restarts at idx 0.
- Back-to-back: second $4014 write issued on the first cycle cpu_ready returns to 1 -> new DMA starts with HALT on the next cycle with the new page.
